// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array controller.
// Holds the FSM state type, default array/config dimensions and the latency
// helpers that fix the token skew of rows, columns and the drain window.
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned NDefault  = 4;
    localparam int unsigned MwDefault = 8;

    // Skew register of row i sees an accepted vector i cycles later.
    function automatic int unsigned row_skew(input int unsigned i);
        return i;
    endfunction

    // Bottom of column j produces the result N+j cycles after the accept.
    function automatic int unsigned col_latency(input int unsigned n, input int unsigned j);
        return n + j;
    endfunction

    // Cycles from the last accept's successor up to the final col_valid[N-1].
    function automatic int unsigned drain_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/valid_delay.sv
// Single-bit token delay line.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset, clears every stage
//   d_i   - token in
//   q_o   - token out, Depth cycles after d_i
module valid_delay #(
    parameter int unsigned Depth = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            // Shift form that also works for Depth == 1.
            sr_q <= (sr_q << 1) | Depth'(d_i);
        end
    end

    assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Controller for an N x N weight-stationary systolic array.
// Sequence per operation: load N weight rows, stream cfg_m input vectors
// (with back-pressure from in_valid bubbles), drain the array, pulse done.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   start, cfg_m     - operation request and vector count (latched in IDLE)
//   in_valid/ready   - input vector handshake
//   w_load_en, w_row - weight row write strobe and row index
//   row_valid        - per-row skewed token valids
//   col_valid        - per-column result valids at the array bottom
//   vec_cnt          - vectors accepted in the current operation
//   busy, done       - not-idle flag and one-cycle completion pulse
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N  = NDefault,
    parameter int unsigned MW = MwDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MW-1:0]        cfg_m,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 w_load_en,
    output logic [$clog2(N)-1:0] w_row,
    output logic [N-1:0]         row_valid,
    output logic [N-1:0]         col_valid,
    output logic [MW-1:0]        vec_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned DW = $clog2(drain_len(N) + 1);

    state_e          state_q, state_d;
    logic [MW-1:0]   cfg_m_q, cfg_m_d;
    logic [MW-1:0]   vec_cnt_q, vec_cnt_d;
    logic [RW-1:0]   w_row_q, w_row_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            accept;

    always_comb begin
        state_d   = state_q;
        cfg_m_d   = cfg_m_q;
        vec_cnt_d = vec_cnt_q;
        w_row_d   = w_row_q;
        drain_d   = drain_q;
        in_ready  = 1'b0;
        w_load_en = 1'b0;
        w_row     = '0;
        done      = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoadW;
                    cfg_m_d   = cfg_m;
                    vec_cnt_d = '0;
                    w_row_d   = '0;
                end
            end
            StLoadW: begin
                w_load_en = 1'b1;
                w_row     = w_row_q;
                if (w_row_q == RW'(N - 1)) begin
                    state_d = (cfg_m_q != '0) ? StStream : StDone;
                end else begin
                    w_row_d = w_row_q + 1'b1;
                end
            end
            StStream: begin
                in_ready = (vec_cnt_q < cfg_m_q);
                accept   = in_valid & in_ready;
                if (accept) begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    // Leave as soon as the final vector is taken; no idle STREAM cycle.
                    if (vec_cnt_q == cfg_m_q - 1'b1) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DW'(drain_len(N) - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cfg_m_q   <= '0;
            vec_cnt_q <= '0;
            w_row_q   <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            cfg_m_q   <= cfg_m_d;
            vec_cnt_q <= vec_cnt_d;
            w_row_q   <= w_row_d;
            drain_q   <= drain_d;
        end
    end

    assign vec_cnt = vec_cnt_q;
    assign busy    = (state_q != StIdle);

    // Row 0 sees the token in the accept cycle itself.
    assign row_valid[0] = accept;

    for (genvar i = 1; i < N; i++) begin : g_row
        valid_delay #(
            .Depth(row_skew(i))
        ) u_row_dly (
            .clk_i(clk),
            .rst_i(rst),
            .d_i  (accept),
            .q_o  (row_valid[i])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        valid_delay #(
            .Depth(col_latency(N, j))
        ) u_col_dly (
            .clk_i(clk),
            .rst_i(rst),
            .d_i  (accept),
            .q_o  (col_valid[j])
        );
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (N=4, MW=8).
// A cycle-indexed reference model derives accept cycles from the in_valid
// pattern and cfg_m, then every output is predicted from those accepts.
module tb_systolic_ctrl;

    localparam int N    = 4;
    localparam int MW   = 8;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MW-1:0] cfg_m;
    logic          in_valid;
    logic          in_ready;
    logic          w_load_en;
    logic [1:0]    w_row;
    logic [N-1:0]  row_valid;
    logic [N-1:0]  col_valid;
    logic [MW-1:0] vec_cnt;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    bit iv  [MAXC];
    bit acc [MAXC];
    bit rdy [MAXC];
    bit sp  [MAXC];

    always #5 clk = ~clk;

    systolic_ctrl #(
        .N (N),
        .MW(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_m    (cfg_m),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_load_en(w_load_en),
        .w_row    (w_row),
        .row_valid(row_valid),
        .col_valid(col_valid),
        .vec_cnt  (vec_cnt),
        .busy     (busy),
        .done     (done)
    );

    // vmode: 0 always valid, 1 random bubbles, 2 single bubble at cycle 6.
    // smode: 0 none, 1 extra start at cycles 3 and 8, 2 random extra starts.
    // rst_at: cycle whose closing edge samples rst (with start), -1 for none.
    task automatic run_op(input int cfg, input int vmode, input int smode, input int rst_at,
                          output int done_at, output int done_n);
        int acc_n, t, dt, lim, cnt_m;
        bit e_load, e_rdy, e_busy, e_done;
        logic [1:0]    e_row;
        logic [N-1:0]  rv, cv;
        logic [MW-1:0] e_cnt;

        for (int c = 0; c < MAXC; c++) begin
            case (vmode)
                0:       iv[c] = 1'b1;
                1:       iv[c] = (c >= 1000) ? 1'b1 : ($urandom_range(3, 0) != 0);
                default: iv[c] = (c != 6);
            endcase
            acc[c] = 1'b0;
            rdy[c] = 1'b0;
            sp[c]  = 1'b0;
        end

        // Reference: loading occupies cycles 1..N, streaming starts at N+1.
        acc_n = 0;
        t     = N + 1;
        if (cfg == 0) begin
            dt = N + 1;
        end else begin
            while (acc_n < cfg) begin
                rdy[t] = 1'b1;
                if (iv[t]) begin
                    acc[t] = 1'b1;
                    acc_n++;
                end
                t++;
            end
            dt = (t - 1) + 2 * N;
        end
        lim = (rst_at >= 0) ? rst_at + 3 : dt + 1;

        if (smode == 1) begin
            sp[3] = 1'b1;
            sp[8] = 1'b1;
        end else if (smode == 2) begin
            for (int c = 1; c <= dt; c++) sp[c] = ($urandom_range(4, 0) == 0);
        end

        done_at = -1;
        done_n  = 0;
        cnt_m   = 0;

        @(posedge clk);
        #1;
        start    = 1'b1;
        cfg_m    = MW'(cfg);
        in_valid = iv[0];
        rst      = 1'b0;

        for (int c = 0; c <= lim; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                start    = sp[c] || (c == rst_at);
                cfg_m    = MW'($urandom);
                in_valid = iv[c];
                rst      = (c == rst_at);
            end
            @(negedge clk);
            if (done === 1'b1) begin
                if (done_at < 0) done_at = c;
                done_n++;
            end
            if (c >= 1) begin
                if (rst_at >= 0 && c > rst_at) begin
                    e_load = 0; e_rdy = 0; e_busy = 0; e_done = 0;
                    e_row = '0; rv = '0; cv = '0; e_cnt = '0;
                end else begin
                    e_load = (c <= N);
                    e_row  = e_load ? 2'(c - 1) : 2'd0;
                    e_rdy  = rdy[c];
                    e_busy = (c <= dt);
                    e_done = (c == dt);
                    e_cnt  = MW'(cnt_m);
                    for (int i = 0; i < N; i++) begin
                        rv[i] = (c - i >= 0) ? acc[c - i] : 1'b0;
                        cv[i] = (c - N - i >= 0) ? acc[c - N - i] : 1'b0;
                    end
                end
                tests += 8;
                if (in_ready !== e_rdy) begin
                    fails++;
                    $display("FAIL in_ready cyc %0d: got %b want %b", c, in_ready, e_rdy);
                end
                if (w_load_en !== e_load) begin
                    fails++;
                    $display("FAIL w_load_en cyc %0d: got %b want %b", c, w_load_en, e_load);
                end
                if (w_row !== e_row) begin
                    fails++;
                    $display("FAIL w_row cyc %0d: got %0d want %0d", c, w_row, e_row);
                end
                if (row_valid !== rv) begin
                    fails++;
                    $display("FAIL row_valid cyc %0d: got %b want %b", c, row_valid, rv);
                end
                if (col_valid !== cv) begin
                    fails++;
                    $display("FAIL col_valid cyc %0d: got %b want %b", c, col_valid, cv);
                end
                if (vec_cnt !== e_cnt) begin
                    fails++;
                    $display("FAIL vec_cnt cyc %0d: got %0d want %0d", c, vec_cnt, e_cnt);
                end
                if (busy !== e_busy) begin
                    fails++;
                    $display("FAIL busy cyc %0d: got %b want %b", c, busy, e_busy);
                end
                if (done !== e_done) begin
                    fails++;
                    $display("FAIL done cyc %0d: got %b want %b", c, done, e_done);
                end
            end
            cnt_m += int'(acc[c]);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        start    = 1'b1;
        cfg_m    = 8'd5;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 8;
        if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst in_ready: got %b want 0", in_ready); end
        if (w_load_en !== 1'b0) begin fails++; $display("FAIL rst w_load_en: got %b want 0", w_load_en); end
        if (w_row !== 2'd0)     begin fails++; $display("FAIL rst w_row: got %0d want 0", w_row); end
        if (row_valid !== '0)   begin fails++; $display("FAIL rst row_valid: got %b want 0", row_valid); end
        if (col_valid !== '0)   begin fails++; $display("FAIL rst col_valid: got %b want 0", col_valid); end
        if (vec_cnt !== '0)     begin fails++; $display("FAIL rst vec_cnt: got %0d want 0", vec_cnt); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin fails++; $display("FAIL rst done: got %b want 0", done); end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_with_rst busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int da, dn;
        run_op(3, 0, 0, -1, da, dn);
        tests++;
        if (da !== 15 || dn !== 1) begin
            fails++;
            $display("FAIL basic done: got cyc %0d count %0d want cyc 15 count 1", da, dn);
        end
    endtask

    task automatic test_bubble();
        int da, dn;
        run_op(3, 2, 0, -1, da, dn);
        tests++;
        if (da !== 16) begin
            fails++;
            $display("FAIL bubble done: got cyc %0d want 16", da);
        end
    endtask

    task automatic test_zero();
        int da, dn;
        run_op(0, 0, 0, -1, da, dn);
        tests++;
        if (da !== 5 || vec_cnt !== 8'd0) begin
            fails++;
            $display("FAIL zero done: got cyc %0d vec_cnt %0d want cyc 5 vec_cnt 0", da, vec_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int da, dn;
        run_op(3, 0, 1, -1, da, dn);
        tests++;
        if (da !== 15 || dn !== 1) begin
            fails++;
            $display("FAIL start_ignored: got cyc %0d count %0d want cyc 15 count 1", da, dn);
        end
    endtask

    task automatic test_reset_mid();
        int da, dn;
        run_op(3, 0, 0, 10, da, dn);
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL reset_mid done count: got %0d want 0", dn);
        end
        run_op(3, 0, 0, -1, da, dn);
        tests++;
        if (da !== 15) begin
            fails++;
            $display("FAIL reset_mid restart done: got cyc %0d want 15", da);
        end
    endtask

    task automatic test_max();
        int da, dn;
        run_op(255, 0, 0, -1, da, dn);
        tests++;
        if (da !== 267 || vec_cnt !== 8'd255) begin
            fails++;
            $display("FAIL max: got done cyc %0d vec_cnt %0d want 267 and 255", da, vec_cnt);
        end
    endtask

    task automatic test_random();
        int da, dn, cfg;
        for (int k = 0; k < 12; k++) begin
            cfg = (k == 0) ? 255 : int'($urandom_range(40, 0));
            run_op(cfg, 1, 2, -1, da, dn);
            tests++;
            if (dn !== 1 || vec_cnt !== MW'(cfg)) begin
                fails++;
                $display("FAIL random run %0d: done count %0d vec_cnt %0d want 1 and %0d",
                         k, dn, vec_cnt, cfg);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        cfg_m    = '0;
        in_valid = 1'b0;
        test_reset();
        test_basic();
        test_bubble();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        test_max();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter: N, default 4, array dimension (N x N PEs, weight-stationary, partial sums flow down columns).
REQ-002 Parameter: MW, default 8, width of cfg_m (vector count).
REQ-003 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  pulse; begins an operation when sampled in IDLE.
REQ-006 Port: cfg_m  in  MW  number of input vectors to stream; latched on accepted start.
REQ-007 Port: in_valid  in  1  upstream has an input vector available.
REQ-008 Port: in_ready  out  1  controller accepts a vector this cycle.
REQ-009 Port: w_load_en  out  1  weight-row write strobe to the weight registers.
REQ-010 Port: w_row  out  $clog2(N)  weight row being loaded.
REQ-011 Port: row_valid  out  N  bit i: skew register of array row i holds valid data.
REQ-012 Port: col_valid  out  N  bit j: bottom accum_out of column j is a valid result.
REQ-013 Port: vec_cnt  out  MW  vectors accepted in current operation.
REQ-014 Port: busy  out  1  high in any state except IDLE.
REQ-015 Port: done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-017 IDLE -> LOAD_W on start; start in any other state is ignored; cfg_m changes after latch have no effect.
REQ-018 LOAD_W lasts exactly N cycles; w_load_en=1 throughout; w_row = 0,1,...,N-1 in successive cycles.
REQ-019 LOAD_W -> STREAM if latched cfg_m>0, else LOAD_W -> DONE.
REQ-020 STREAM: in_ready=1 while vec_cnt<cfg_m; accept = in_valid & in_ready; vec_cnt increments on accept.
REQ-021 in_valid low in STREAM inserts a bubble: no accept, no valid token, state held; no timeout.
REQ-022 STREAM -> DRAIN in the cycle after the accept that makes vec_cnt==cfg_m.
REQ-023 row_valid[0]=accept (same cycle); row_valid[i] = accept delayed i cycles.
REQ-024 col_valid[j] = accept delayed N+j cycles; bubbles propagate as 0.
REQ-025 DRAIN lasts exactly 2N-1 cycles, ending in the cycle of the final col_valid[N-1]; then DONE.
REQ-026 DONE lasts one cycle with done=1, then IDLE; vec_cnt holds its final value until next accepted start clears it.
REQ-027 in_ready, w_load_en are 0 outside STREAM/LOAD_W respectively; w_row=0 when w_load_en=0.
REQ-028 vec_cnt never wraps: cfg_m=2^MW-1 is the maximum and completes normally.

Reset
REQ-029 rst=1 at any edge forces IDLE regardless of state, including mid-STREAM/DRAIN.
REQ-030 Reset values: in_ready=0, w_load_en=0, w_row=0, row_valid=0, col_valid=0, vec_cnt=0, busy=0, done=0; delay lines cleared, pending tokens dropped.
REQ-031 start asserted in the same cycle as rst is ignored.

Structure
REQ-032 Shared package systolic_pkg holds: state enum type, default N, MW, and latency constant functions (row skew i, column latency N+j, drain length 2N-1).
REQ-033 One sub-module valid_delay (parameterised depth, 1-bit, synchronous reset to 0) implements each token delay line.

Verification (N=4, MW=8; start sampled at cycle 0)
REQ-034 cfg_m=3, in_valid=1: w_load_en cycles 1-4 with w_row 0,1,2,3; accepts at 5,6,7; col_valid[0] at 9,10,11; col_valid[3] at 12,13,14; done=1 at cycle 15 only; busy cycles 1-15.
REQ-035 cfg_m=3, in_valid low cycle 6: accepts at 5,7,8; row_valid[2] at 7,9,10; DRAIN starts 9; done at 16.
REQ-036 cfg_m=0: w_load_en cycles 1-4, no in_ready, no valids, done at cycle 5.
REQ-037 start pulsed at cycles 3 and 8 during cfg_m=3 run: no effect; single done at 15.
REQ-038 rst at cycle 10 mid-DRAIN: cycle 11 busy=0, col_valid=0, vec_cnt=0; no done; fresh start then completes per REQ-034 timing.
REQ-039 cfg_m=255, in_valid=1: exactly 255 accepts, vec_cnt ends 255, done at cycle 5+255+7 = 267.
